// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_pkg;

    // Width of the saturating taken-jump counter.
    localparam int TAKEN_W = 16;

    // Power-on contents of branch-target table entries 0..7 (12-bit two's complement).
    localparam logic signed [11:0] PC_DEFAULT_TABLE [8] = '{
        12'sd1, -12'sd1, 12'sd24, -12'sd28, 12'sd124, -12'sd128, 12'sd149, -12'sd157
    };

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

    // Sign-extended default for table entry i; entries past the hardwired set reset to 0.
    function automatic logic signed [63:0] pc_default(input int i);
        if (i >= 0 && i < 8) begin
            return 64'(PC_DEFAULT_TABLE[i[2:0]]);
        end
        return '0;
    endfunction

endpackage

// File: rtl/pc_target_table.sv
// N x D branch-target register file: one write port, one combinational read port.
// Out-of-range indices (N not a power of two) read as 0 and drop writes.
module pc_target_table
    import pc_pkg::*;
#(
    parameter int D  = 12,
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [D-1:0]  wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [D-1:0]  rd_data
);

    logic [D-1:0] regs [N];

    // Reset loads the defaults; otherwise accept in-range writes on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= D'(pc_default(i));
            end
        end else if (wr_en && (32'(wr_idx) < N)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Read path sees the stored value, so a same-edge write is not forwarded.
    assign rd_data = (32'(rd_idx) < N) ? regs[rd_idx] : '0;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, stall, relative/absolute jumps through
// a writable target table, sticky halt, and a saturating taken-jump counter.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int           D     = 12,
    parameter int           N     = 8,
    parameter logic [D-1:0] START = '0,
    parameter int           IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Stall,
    input  logic               Halt,
    input  logic               Jump_rel,
    input  logic               Jump_abs,
    input  logic [IW-1:0]      How_high,
    input  logic               Wr_en,
    input  logic [IW-1:0]      Wr_idx,
    input  logic [D-1:0]       Wr_data,
    output logic [D-1:0]       PC,
    output logic [D-1:0]       Target,
    output logic               Done,
    output logic [TAKEN_W-1:0] Taken_cnt
);

    pc_state_e          state;
    logic [D-1:0]       pc_q;
    logic               done_q;
    logic [TAKEN_W-1:0] taken_q;
    logic [D-1:0]       tgt;

    pc_target_table #(
        .D  (D),
        .N  (N),
        .IW (IW)
    ) u_table (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .wr_en   (Wr_en),
        .wr_idx  (Wr_idx),
        .wr_data (Wr_data),
        .rd_idx  (How_high),
        .rd_data (tgt)
    );

    // RUN/HALTED control with next-PC priority Halt > Stall > Jump_abs > Jump_rel > +1.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= RUN;
            pc_q    <= START;
            done_q  <= 1'b0;
            taken_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (Halt) begin
                        state  <= HALTED;
                        done_q <= 1'b1;
                    end else if (!Stall) begin
                        if (Jump_abs) begin
                            pc_q <= tgt;
                        end else if (Jump_rel) begin
                            pc_q <= pc_q + tgt;
                        end else begin
                            pc_q <= pc_q + D'(1);
                        end
                        // One count per applied jump, even when both jump requests are high.
                        if ((Jump_abs || Jump_rel) && (taken_q != '1)) begin
                            taken_q <= taken_q + TAKEN_W'(1);
                        end
                    end
                end
                default: begin
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    assign PC        = pc_q;
    assign Done      = done_q;
    assign Taken_cnt = taken_q;
    assign Target    = tgt;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the core fetch stage: holds the D-bit PC and advances it each cycle. It takes relative or absolute jumps through a runtime-writable branch-target table of N entries, which replaces the fixed 8-entry hardwired offset lookup. It also provides stall, a sticky halt/done state, and a saturating taken-jump counter for the test harness.

## Interface
- D, 12, PC and target width (bits)
- N, 8, branch-target table depth; index width IW = $clog2(N), minimum 1
- START, 0, PC value loaded on reset
- Clk  input  1  rising-edge clock
- Reset_n  input  1  synchronous, active-low reset
- Stall  input  1  hold PC this cycle
- Halt  input  1  enter HALTED; sticky until reset
- Jump_rel  input  1  PC <= PC + table[How_high]
- Jump_abs  input  1  PC <= table[How_high]
- How_high  input  IW  table index for jumps and for the Target read
- Wr_en  input  1  write table entry
- Wr_idx  input  IW  write index
- Wr_data  input  D  write value (two's complement offset or absolute address)
- PC  output  D  current program counter (registered)
- Target  output  D  table[How_high], combinational read
- Done  output  1  high in HALTED (registered)
- Taken_cnt  output  16  count of jumps taken, saturating (registered)

## Operation
- One clock and one reset: Clk, with Reset_n synchronous and active-low.
- States: RUN, HALTED. Reset puts the block in RUN.
- RUN to HALTED when Halt = 1 on an edge. HALTED is left only by reset.
- Next-PC priority in RUN, highest first:
  - Halt: PC holds, enter HALTED.
  - Stall: PC holds.
  - Jump_abs: PC <= table[How_high].
  - Jump_rel: PC <= PC + table[How_high].
  - Otherwise: PC <= PC + 1.
- Jump_abs and Jump_rel both high: Jump_abs wins. Taken_cnt increments once.
- Arithmetic is modulo 2^D and the table value is two's complement. Examples with D = 12:
  - PC = 0xFFF, increment gives 0x000.
  - PC = 4, offset -5 (0xFFB) gives 0xFFF.
- Taken_cnt increments on every cycle where a jump is actually applied (not stalled, not halted). It saturates at 0xFFFF.
- Table writes:
  - Accepted in RUN and HALTED, including during Stall.
  - The write lands on the edge; the new value is visible on Target and usable by jumps from the next cycle.
  - A jump and a write to the same index on the same edge: the jump uses the old value.
- Reset contents of the table (package constant), entries 0–7: 1, -1, 24, -28, 124, -128, 149, -157.
  - Entries at index 8 and above reset to 0.
  - For N < 8, only the first N default entries are loaded.
- How_high or Wr_idx ≥ N when N is not a power of two:
  - Target reads 0.
  - A jump through that index still counts as taken.
  - The write is ignored.

## Timing
- Reset (Reset_n = 0 at an edge) sets:
  - PC = START, Done = 0, Taken_cnt = 0.
  - State RUN and table = defaults.
  - All other inputs are ignored that cycle.
- Reset mid-operation (any state, any pending write) takes effect on that edge.
- PC latency is 1 cycle: controls sampled at edge k set PC after edge k.
- Done rises the cycle after Halt is sampled. PC keeps the value it had when Halt was sampled.
- Target is combinational from How_high and the current table contents: zero latency for reads, one cycle for writes.
- No handshakes. Every input is sampled every edge.

## Structure
- Package pc_pkg holds:
  - the default-table constant (array of 8 × 12-bit values, sign-extended or truncated to D);
  - the state enum {RUN, HALTED};
  - the Taken_cnt width constant.
- One sub-module, pc_target_table: N×D register file with one write port, one combinational read port, and synchronous active-low reset to the defaults.
- The top level holds the PC register, state, next-PC mux, adder and counter.

## Test plan
- Reset then 3 free-running cycles with no controls: PC = 0, 1, 2, 3. Done = 0, Taken_cnt = 0.
- At PC = 4, Jump_rel with How_high = 1 (-1): PC = 3. Then Jump_rel with How_high = 3 (-28): PC = 0xFE7. Taken_cnt = 2.
- Wr_en to index 2 with 0x100 while Jump_rel uses How_high = 2 on the same edge, from PC = 0: PC = 24 (old value). Next Jump_abs with How_high = 2: PC = 0x100, Target = 0x100.
- Stall and Jump_abs asserted together for 2 cycles: PC holds and Taken_cnt is unchanged. Release Stall: the jump applies.
- Halt at PC = 7: Done = 1 next cycle and PC stays 7 for 10 cycles regardless of jumps. Reset_n = 0: PC = START, Done = 0, table entry 2 = 24 again.
- Wrap and saturation: PC = 0xFFF increments to 0x000. Force 65536 jumps: Taken_cnt holds at 0xFFFF.
